pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
//  Generic parametrised pipeline stage register for the MIPS core. Supersedes the fixed per-stage
//  registers (IF/ID ... MEM/WB) driven by the stall vector.
//  Carries an opaque DATA_W payload with a valid/ready handshake, a synchronous flush and a
//  saturating backpressure counter.
//  An optional 2-entry skid buffer registers the ready path, for timing closure on long stage-to-stage wires.
// PARAMETERS
//  DATA_W  173  payload width in bits; default fits the MEM/WB field set (wd, wreg, wdata, hi, lo, whilo, cp0 we/addr/data, pc)
//  CNT_W   16   width of the stall_cnt performance counter
// PORTS
//  clk        in   1       clock; all state changes on posedge
//  rst        in   1       reset, synchronous, active-high
//  flush      in   1       synchronous squash of all held entries (exception/eret); active-high
//  up_valid   in   1       upstream holds a valid payload
//  up_ready   out  1       stage accepts a payload this cycle
//  up_data    in   DATA_W  upstream payload
//  dn_valid   out  1       stage presents a valid payload downstream
//  dn_ready   in   1       downstream consumes the payload this cycle
//  dn_data    out  DATA_W  payload to the next stage; all-zero whenever dn_valid=0
//  stall_cnt  out  CNT_W   count of cycles with dn_valid=1 and dn_ready=0
// BEHAVIOUR
//  - Handshakes:
//      accept  = up_valid & up_ready.
//      consume = dn_valid & dn_ready.
//      Both evaluated at posedge clk.
//  - Priority per edge: rst > flush > normal handshake.
//  - Reset: dn_valid=0, dn_data=0, stall_cnt=0, every internal valid/data register cleared.
//    Reset mid-transfer drops all held payloads; no partial output.
//    up_ready=1 the cycle after reset.
//  - Flush:
//      * Next edge: all entries invalid, data registers zero, dn_valid=0.
//      * A payload offered (accept) in the flush cycle is discarded.
//      * stall_cnt is not affected by flush.
//  - Latency: 1 cycle; a payload accepted at edge N appears on dn_data after edge N.
//  - Throughput: 1 payload/cycle under continuous up_valid and dn_ready.
//  - Ordering: FIFO; a payload is never duplicated or dropped except by rst/flush.
//  - Bubble: when the stage drains (consume, no accept), the output data register is loaded with zero.
//  - dn_valid and dn_data come straight from flops (no combinational path from up_* to dn_*).
//  - stall_cnt:
//      * +1 on every edge where dn_valid & ~dn_ready.
//      * Saturates at 2^CNT_W-1 (no wrap).
//      * Cleared only by rst.
// CONFIGURATION
//  SKID_BUF_EN undefined: single register, no skid state.
//    - up_ready = ~dn_valid | dn_ready (combinational from dn_ready).
//    - Simultaneous consume+accept replaces the entry in the same edge.
//  SKID_BUF_EN defined: main + skid register, up_ready = ~skid_valid (registered, no dn_ready->up_ready path).
//    FSM:
//      EMPTY -accept-> MAIN
//      MAIN  -accept&~consume-> SKID
//      MAIN  -consume&~accept-> EMPTY
//      MAIN  -accept&consume-> MAIN (new data)
//      SKID  -consume-> MAIN (skid moves to main, skid cleared to 0)
//      SKID  never accepts (up_ready=0)
//    - flush from any state -> EMPTY.
//    - Latency and FIFO order identical to the undefined case.
// TESTING
//  1 rst held 2 cycles mid-stream -> next cycle dn_valid=0, dn_data=0, stall_cnt=0, up_ready=1.
//  2 up_valid=1, data 0x1,0x2,0x3 back-to-back, dn_ready=1 -> dn_data 0x1,0x2,0x3 on 3 consecutive cycles, 1-cycle latency.
//  3 dn_ready=0 for 4 cycles holding 0xA, up offering 0xB:
//      -> 0xA stable; stall_cnt=4; no loss, no duplication.
//      -> SKID_BUF_EN: 0xB captured, up_ready=0 from the 2nd cycle; without it up_ready=0 throughout.
//      -> release dn_ready -> 0xA then 0xB.
//  4 flush=1 while stage full (SKID state) and up_valid=1 with 0xC -> next cycle dn_valid=0, dn_data=0; 0xC never appears.
//  5 CNT_W=4, dn_valid=1, dn_ready=0 for 20 cycles -> stall_cnt sticks at 15.
//  6 random valid/ready, 10k payloads, both macro settings -> scoreboard: in-order, lossless, dn_data=0 whenever dn_valid=0.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and stall counter.
// Optional skid buffer (registered ready path) selected by defining SKID_BUF_EN.
module pipe_stage_hs #(
    parameter int DATA_W = 173,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // A transfer happens on a posedge where valid and ready are both high;
    // valid may not depend on ready, and held data must stay stable until transferred.
    logic accept;
    logic consume;

    assign accept  = up_valid & up_ready;
    assign consume = dn_valid & dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (dn_valid && !dn_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef SKID_BUF_EN
    // Encoding chosen so dn_valid and up_ready are direct state flop bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MAIN  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_MAIN;
                        main_d  = up_data;
                    end
                end
                ST_MAIN: begin
                    if (accept && consume) begin
                        main_d = up_data;
                    end else if (accept) begin
                        state_d = ST_SKID;
                        skid_d  = up_data;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        state_d = ST_MAIN;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    assign dn_valid = state_q[0];
    assign up_ready = ~state_q[1];
    assign dn_data  = main_q;
`else
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= up_data;
        end else if (consume) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
    end

    assign dn_valid = valid_q;
    assign up_ready = ~valid_q | dn_ready;
    assign dn_data  = data_q;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: reset/table vectors, stall, flush, saturation, random scoreboard.
// Builds against either setting of SKID_BUF_EN.
module tb_pipe_stage_hs;
    localparam int DW = 173;
    localparam int CW = 16;
`ifdef SKID_BUF_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          up_valid = 1'b0;
    logic          dn_ready = 1'b0;
    logic [DW-1:0] up_data = '0;
    logic          up_ready, dn_valid, sat_up_ready, sat_dn_valid;
    logic [DW-1:0] dn_data, sat_dn_data;
    logic [CW-1:0] stall_cnt;
    logic [3:0]    sat_cnt;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(up_ready),
        .up_data(up_data), .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_hs #(.DATA_W(DW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(sat_up_ready),
        .up_data(up_data), .dn_valid(sat_dn_valid), .dn_ready(dn_ready), .dn_data(sat_dn_data),
        .stall_cnt(sat_cnt)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle from posedge+1; report whether the payload was accepted.
    task automatic drive(input logic uv, input logic [DW-1:0] d, input logic dr,
                         input logic fl, output logic acc);
        up_valid = uv;
        up_data  = d;
        dn_ready = dr;
        flush    = fl;
        #1;
        acc = uv & up_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r = {r[DW-33:0], $urandom()};
        return r;
    endfunction

    // Scoreboard: push on accept, pop on consume, drop held entries on rst/flush.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (!dn_valid) chk("bubble_zero", dn_data, '0);
            if (dn_valid && dn_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected nothing", dn_data);
                end else begin
                    chk("sb_order", dn_data, exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            else if (up_valid && up_ready) exp_q.push_back(up_data);
        end
    end

    typedef struct {
        logic          uv;
        logic [DW-1:0] ud;
        logic          fl;
        logic          exp_dv;
        logic [DW-1:0] exp_dd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic acc;
        logic b_pend;
        logic acc_first;
        int   sent;
        int   cyc;

        vecs[0]  = '{1'b1, 'h1,  1'b0, 1'b1, 'h1};
        vecs[1]  = '{1'b1, 'h2,  1'b0, 1'b1, 'h2};
        vecs[2]  = '{1'b1, 'h3,  1'b0, 1'b1, 'h3};
        vecs[3]  = '{1'b0, 'h4,  1'b0, 1'b0, 'h0};
        vecs[4]  = '{1'b1, 'h5,  1'b0, 1'b1, 'h5};
        vecs[5]  = '{1'b0, 'h6,  1'b0, 1'b0, 'h0};
        vecs[6]  = '{1'b0, 'h7,  1'b0, 1'b0, 'h0};
        vecs[7]  = '{1'b1, 'h8,  1'b0, 1'b1, 'h8};
        vecs[8]  = '{1'b1, 'h9,  1'b1, 1'b0, 'h0};
        vecs[9]  = '{1'b1, 'hA,  1'b0, 1'b1, 'hA};
        vecs[10] = '{1'b0, 'hB,  1'b1, 1'b0, 'h0};
        vecs[11] = '{1'b1, 'h77, 1'b0, 1'b1, 'h77};
        vecs[12] = '{1'b0, 'h0,  1'b0, 1'b0, 'h0};

        // Initial reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_dn_valid", DW'(dn_valid), '0);
        chk("rst_dn_data", dn_data, '0);
        chk("rst_stall_cnt", DW'(stall_cnt), '0);
        chk("rst_up_ready", DW'(up_ready), DW'(1));
        @(posedge clk);
        #1;

        // Table vectors, dn_ready held high: identical in both configurations
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].uv, vecs[i].ud, 1'b1, vecs[i].fl, acc);
            chk($sformatf("vec%0d_dn_valid", i), DW'(dn_valid), DW'(vecs[i].exp_dv));
            chk($sformatf("vec%0d_dn_data", i), dn_data, vecs[i].exp_dd);
            chk($sformatf("vec%0d_up_ready", i), DW'(up_ready), DW'(1));
            chk($sformatf("vec%0d_stall_cnt", i), DW'(stall_cnt), '0);
        end

        // Reset held 2 cycles mid-stream
        for (int i = 0; i < 3; i++) drive(1'b1, rnd(), 1'b0, 1'b0, acc);
        rst = 1'b1;
        drive(1'b1, rnd(), 1'b0, 1'b0, acc);
        drive(1'b1, rnd(), 1'b0, 1'b0, acc);
        rst = 1'b0;
        up_valid = 1'b0;
        #1;
        chk("midrst_dn_valid", DW'(dn_valid), '0);
        chk("midrst_dn_data", dn_data, '0);
        chk("midrst_stall_cnt", DW'(stall_cnt), '0);
        chk("midrst_sat_cnt", DW'(sat_cnt), '0);
        chk("midrst_up_ready", DW'(up_ready), DW'(1));

        // Stall: hold 0xA for 4 cycles while 0xB is offered
        drive(1'b1, 'hA, 1'b0, 1'b0, acc);
        chk("stall_load", dn_data, 'hA);
        b_pend = 1'b1;
        acc_first = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(b_pend, 'hB, 1'b0, 1'b0, acc);
            if (k == 1) acc_first = acc;
            if (acc) b_pend = 1'b0;
            chk($sformatf("stall%0d_dn_data", k), dn_data, 'hA);
            chk($sformatf("stall%0d_dn_valid", k), DW'(dn_valid), DW'(1));
            chk($sformatf("stall%0d_cnt", k), DW'(stall_cnt), DW'(k));
            chk($sformatf("stall%0d_up_ready", k), DW'(up_ready), '0);
        end
        chk("stall_first_accept", DW'(acc_first), DW'(SKID));
        drive(b_pend, 'hB, 1'b1, 1'b0, acc);
        chk("release_dn_data_b", dn_data, 'hB);
        chk("release_dn_valid", DW'(dn_valid), DW'(1));
        chk("release_cnt", DW'(stall_cnt), DW'(4));
        drive(1'b0, '0, 1'b1, 1'b0, acc);
        chk("release_drained", DW'(dn_valid), '0);
        chk("release_zero", dn_data, '0);

        // Flush with the stage full and 0xC offered
        drive(1'b1, 'h11, 1'b0, 1'b0, acc);
        drive(1'b1, 'h22, 1'b0, 1'b0, acc);
        drive(1'b1, 'hC, 1'b0, 1'b1, acc);
        chk("flush_dn_valid", DW'(dn_valid), '0);
        chk("flush_dn_data", dn_data, '0);
        chk("flush_up_ready", DW'(up_ready), DW'(1));
        chk("flush_cnt", DW'(stall_cnt), DW'(6));
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, acc);
            chk($sformatf("post_flush%0d_dn_valid", k), DW'(dn_valid), '0);
        end

        // Saturation on the CNT_W=4 instance (counters at 6 here)
        drive(1'b1, 'h5, 1'b0, 1'b0, acc);
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0, acc);
            if (k == 9)  chk("sat_reach", DW'(sat_cnt), DW'(15));
            if (k == 10) chk("sat_hold_wide", DW'(stall_cnt), DW'(16));
        end
        chk("sat_final", DW'(sat_cnt), DW'(15));
        chk("sat_wide_final", DW'(stall_cnt), DW'(26));
        chk("sat_data_held", dn_data, 'h5);
        drive(1'b0, '0, 1'b1, 1'b0, acc);

        // Random traffic through the scoreboard
        sent = 0;
        cyc = 0;
        b_pend = 1'b0;
        up_data = '0;
        while (sent < 10000 && cyc < 60000) begin
            logic fl;
            logic [DW-1:0] d;
            fl = ($urandom_range(63) == 0);
            if (!b_pend && $urandom_range(3) != 0) begin
                b_pend = 1'b1;
                d = rnd();
            end else begin
                d = b_pend ? up_data : '0;
            end
            drive(b_pend, d, ($urandom_range(3) != 0), fl, acc);
            if (acc) begin
                b_pend = 1'b0;
                if (!fl) sent++;
            end
            cyc++;
        end
        if (sent < 10000) begin
            checks++;
            errors++;
            $display("FAIL random_budget: got %0d payloads required 10000", sent);
        end
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) drive(1'b0, '0, 1'b1, 1'b0, acc);
        drive(1'b0, '0, 1'b1, 1'b0, acc);
        chk("drain_empty", DW'(exp_q.size()), '0);
        chk("drain_dn_valid", DW'(dn_valid), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
